// File: rtl/mix_core_iter_if.sv
// Handshake bundle for mix_core_iter.
//   master : job source / result sink side (drives job, out_ready, abort)
//   slave  : the core (drives in_ready, out_valid, out_data)
// Signals:
//   in_valid/in_ready/in_data/in_fin : job offer, lane i = in_data[i*WIDTH +: WIDTH]
//   abort                            : synchronous cancel of a running job
//   out_valid/out_ready/out_data     : result handoff, same lane packing
interface mix_core_iter_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NLANES = 8
) ();

   logic                      in_valid;
   logic                      in_ready;
   logic [NLANES*WIDTH-1:0]   in_data;
   logic                      in_fin;
   logic                      abort;
   logic                      out_valid;
   logic                      out_ready;
   logic [NLANES*WIDTH-1:0]   out_data;

   modport master (
      output in_valid, in_data, in_fin, abort, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_fin, abort, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/mix_core_iter.sv
// Iterative lane-mixing core.
// Loads NLANES words of WIDTH bits, runs ROUNDS chained add/sub rounds (one per clock),
// optionally one multiply-add finaliser cycle, then presents the state over valid/ready.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   bus        : mix_core_iter_if slave (job in, result out, abort)
//   busy       : high while in ROUND or FINAL
//   jobs_done  : results handed off, wraps at 2^16
module mix_core_iter #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NLANES = 8,
   parameter int unsigned ROUNDS = 12,
   parameter int unsigned MULT   = 19
) (
   input  logic              clk,
   input  logic              rst,
   mix_core_iter_if.slave    bus,
   output logic              busy,
   output logic [15:0]       jobs_done
);

   localparam int unsigned RndW = $clog2(ROUNDS + 1);
   localparam logic [WIDTH-1:0] MultW = WIDTH'(MULT);
   localparam logic [RndW-1:0] LastRnd = RndW'(ROUNDS - 1);

   typedef logic [NLANES-1:0][WIDTH-1:0] lanes_t;

   typedef enum logic [1:0] {
      StIdle,
      StRound,
      StFinal,
      StOut
   } state_e;

   state_e          state_q, state_d;
   lanes_t          lanes_q, lanes_d;
   logic [RndW-1:0] rnd_q, rnd_d;
   logic            fin_q, fin_d;
   logic [15:0]     jobs_q, jobs_d;

   lanes_t round_lanes;
   lanes_t final_lanes;

   // One full mixing round. Lanes are updated in index order and later lanes see the
   // already-updated earlier ones; lane 0 therefore mixes in the old top two lanes.
   always_comb begin
      lanes_t s;
      s = lanes_q;
      s[0] = s[0] + WIDTH'(rnd_q);
      for (int unsigned i = 0; i < NLANES; i++) begin
         s[i] = s[i] + s[(i + NLANES - 1) % NLANES] - s[(i + NLANES - 2) % NLANES];
      end
      round_lanes = s;
   end

   always_comb begin
      final_lanes = lanes_q;
      for (int unsigned i = 0; i < NLANES; i++) begin
         final_lanes[i] = lanes_q[i] * MultW + WIDTH'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      lanes_d = lanes_q;
      rnd_d   = rnd_q;
      fin_d   = fin_q;
      jobs_d  = jobs_q;

      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               lanes_d = bus.in_data;
               fin_d   = bus.in_fin;
               rnd_d   = '0;
               state_d = StRound;
            end
         end
         StRound: begin
            if (bus.abort) begin
               // Cancelled job leaves the partially mixed lanes in place.
               state_d = StIdle;
            end else begin
               lanes_d = round_lanes;
               if (rnd_q == LastRnd) begin
                  state_d = fin_q ? StFinal : StOut;
               end else begin
                  rnd_d = rnd_q + RndW'(1);
               end
            end
         end
         StFinal: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else begin
               lanes_d = final_lanes;
               state_d = StOut;
            end
         end
         StOut: begin
            // abort is ignored here: a finished result must be drained.
            if (bus.out_ready) begin
               jobs_d  = jobs_q + 16'd1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         lanes_q <= '0;
         rnd_q   <= '0;
         fin_q   <= 1'b0;
         jobs_q  <= '0;
      end else begin
         state_q <= state_d;
         lanes_q <= lanes_d;
         rnd_q   <= rnd_d;
         fin_q   <= fin_d;
         jobs_q  <= jobs_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StOut);
   assign bus.out_data  = lanes_q;
   assign busy          = (state_q == StRound) || (state_q == StFinal);
   assign jobs_done     = jobs_q;

endmodule

// File: tb/tb_mix_core_iter.sv
// Directed bench for mix_core_iter with WIDTH=8, NLANES=4, MULT=3.
// dut_a runs ROUNDS=1, dut_b runs ROUNDS=2; both share clock and reset.
module tb_mix_core_iter;

   localparam logic [31:0] InVec   = 32'h03020100; // lanes {0,1,2,3}
   localparam logic [31:0] ExpR1   = 32'h0400FF01; // {1,255,0,4}
   localparam logic [31:0] ExpR1F  = 32'h0F02FE03; // {3,254,2,15}
   localparam logic [31:0] ExpR2   = 32'hFEFB0106; // {6,1,251,254}

   logic        clk;
   logic        rst;
   logic        busy_a, busy_b;
   logic [15:0] jobs_a, jobs_b;

   int checks;
   int failures;

   mix_core_iter_if #(.WIDTH(8), .NLANES(4)) bus_a ();
   mix_core_iter_if #(.WIDTH(8), .NLANES(4)) bus_b ();

   mix_core_iter #(.WIDTH(8), .NLANES(4), .ROUNDS(1), .MULT(3)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_a),
      .busy      (busy_a),
      .jobs_done (jobs_a)
   );

   mix_core_iter #(.WIDTH(8), .NLANES(4), .ROUNDS(2), .MULT(3)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_b),
      .busy      (busy_b),
      .jobs_done (jobs_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a job to dut_a for one accept edge.
   task automatic start_a(input logic [31:0] data, input logic fin);
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = data;
      bus_a.in_fin   = fin;
      tick();
      bus_a.in_valid = 1'b0;
   endtask

   task automatic drain_a();
      bus_a.out_ready = 1'b1;
      tick();
      bus_a.out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] held;
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_fin = 1'b0;
      bus_a.abort = 1'b0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_fin = 1'b0;
      bus_b.abort = 1'b0; bus_b.out_ready = 1'b0;
      #2;
      check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
      check("rst_out_data", bus_a.out_data, 32'd0);
      check("rst_jobs", 32'(jobs_a), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // 1: ROUNDS=1, no finaliser
      start_a(InVec, 1'b0);
      check("t1_busy", 32'(busy_a), 32'd1);
      check("t1_in_ready", 32'(bus_a.in_ready), 32'd0);
      tick();
      check("t1_out_valid", 32'(bus_a.out_valid), 32'd1);
      check("t1_out_data", bus_a.out_data, ExpR1);
      drain_a();
      check("t1_jobs", 32'(jobs_a), 32'd1);
      check("t1_idle", 32'(bus_a.in_ready), 32'd1);

      // 2: ROUNDS=1 with finaliser
      start_a(InVec, 1'b1);
      tick();
      check("t2_final_busy", 32'(busy_a), 32'd1);
      check("t2_final_no_valid", 32'(bus_a.out_valid), 32'd0);
      tick();
      check("t2_out_valid", 32'(bus_a.out_valid), 32'd1);
      check("t2_out_data", bus_a.out_data, ExpR1F);
      drain_a();
      check("t2_jobs", 32'(jobs_a), 32'd2);

      // 3: ROUNDS=2, round constant enters the second round
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = InVec;
      bus_b.in_fin   = 1'b0;
      tick();
      bus_b.in_valid = 1'b0;
      tick();
      check("t3_mid_no_valid", 32'(bus_b.out_valid), 32'd0);
      check("t3_mid_busy", 32'(busy_b), 32'd1);
      tick();
      check("t3_out_valid", 32'(bus_b.out_valid), 32'd1);
      check("t3_out_data", bus_b.out_data, ExpR2);
      bus_b.out_ready = 1'b1;
      tick();
      bus_b.out_ready = 1'b0;
      check("t3_jobs", 32'(jobs_b), 32'd1);

      // 4: back-pressure in OUT; new offers and abort must be ignored
      start_a(InVec, 1'b0);
      tick();
      held = bus_a.out_data;
      check("t4_first", held, ExpR1);
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 32'hA5A5A5A5;
      bus_a.abort    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_hold_data", bus_a.out_data, ExpR1);
         check("t4_hold_valid", 32'(bus_a.out_valid), 32'd1);
         check("t4_hold_in_ready", 32'(bus_a.in_ready), 32'd0);
         check("t4_hold_jobs", 32'(jobs_a), 32'd2);
      end
      bus_a.in_valid = 1'b0;
      bus_a.abort    = 1'b0;
      drain_a();
      check("t4_jobs", 32'(jobs_a), 32'd3);
      check("t4_idle_ready", 32'(bus_a.in_ready), 32'd1);
      check("t4_idle_busy", 32'(busy_a), 32'd0);

      // 5: abort mid-ROUND, then abort ignored while IDLE accepts a job
      start_a(32'h11223344, 1'b1);
      bus_a.abort = 1'b1;
      tick();
      bus_a.abort = 1'b0;
      check("t5_abort_idle", 32'(bus_a.in_ready), 32'd1);
      check("t5_abort_busy", 32'(busy_a), 32'd0);
      check("t5_abort_valid", 32'(bus_a.out_valid), 32'd0);
      tick();
      check("t5_still_no_valid", 32'(bus_a.out_valid), 32'd0);
      check("t5_jobs", 32'(jobs_a), 32'd3);
      bus_a.abort = 1'b1;
      start_a(InVec, 1'b0);
      bus_a.abort = 1'b0;
      check("t5_accept_busy", 32'(busy_a), 32'd1);
      tick();
      check("t5_out_valid", 32'(bus_a.out_valid), 32'd1);
      check("t5_out_data", bus_a.out_data, ExpR1);
      drain_a();
      check("t5_jobs_after", 32'(jobs_a), 32'd4);

      // 6: asynchronous reset mid-ROUND
      start_a(InVec, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_valid", 32'(bus_a.out_valid), 32'd0);
      check("t6_rst_busy", 32'(busy_a), 32'd0);
      check("t6_rst_data", bus_a.out_data, 32'd0);
      check("t6_rst_jobs", 32'(jobs_a), 32'd0);
      check("t6_rst_ready", 32'(bus_a.in_ready), 32'd1);
      tick();
      rst = 1'b0;

      // 6b: back-to-back jobs, three cycles each, counter wraps
      bus_a.in_valid  = 1'b1;
      bus_a.in_data   = InVec;
      bus_a.in_fin    = 1'b0;
      bus_a.out_ready = 1'b1;
      repeat (3 * 65535) tick();
      check("t6_jobs_max", 32'(jobs_a), 32'd65535);
      repeat (3) tick();
      check("t6_jobs_wrap", 32'(jobs_a), 32'd0);
      bus_a.in_valid  = 1'b0;
      bus_a.out_ready = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
